dct_frame_sequencer: RTL and testbench

Frame-level controller for `dct_top`. Reads an 8-bit greyscale image from a raster-ordered synchronous pixel RAM and streams it into `dct_top` in 8x8 block order. Counts the DCT pipeline latency and flushes the pipeline after the last pixel. Re-emits the 12-bit coefficients with a valid strobe and block/coefficient tags, so the downstream quantiser/entropy stage never needs to know the DCT latency.

---
 rtl/dct_frame_sequencer_if.sv | 52 +++++
 rtl/dct_frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_dct_frame_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dct_frame_sequencer_if.sv
// Frame sequencer bus: frame handshake, pixel RAM port,
// dct_top feed/return and the tagged coefficient stream.
interface dct_frame_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int BLK_W  = 10
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic [7:0]        dct_data_in;
    logic              dct_enb;
    logic [11:0]       dct_data_out;
    logic [11:0]       coef_data;
    logic              coef_valid;
    logic [BLK_W-1:0]  coef_blk;
    logic [5:0]        coef_idx;

    modport master (
        input  start,
        input  mem_rd_data,
        input  dct_data_out,
        output busy,
        output done,
        output mem_rd_en,
        output mem_addr,
        output dct_data_in,
        output dct_enb,
        output coef_data,
        output coef_valid,
        output coef_blk,
        output coef_idx
    );

    modport slave (
        output start,
        output mem_rd_data,
        output dct_data_out,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_addr,
        input  dct_data_in,
        input  dct_enb,
        input  coef_data,
        input  coef_valid,
        input  coef_blk,
        input  coef_idx
    );
endinterface

// File: rtl/dct_frame_sequencer.sv
// Streams a raster image into dct_top in 8x8 block order and
// re-emits its coefficients with valid, block and index tags.
module dct_frame_sequencer #(
    parameter int IMG_W       = 256,
    parameter int IMG_H       = 256,
    parameter int DCT_LATENCY = 147,
    parameter int ADDR_W      = 16,
    parameter int BLK_W       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    dct_frame_sequencer_if.master bus
);
    localparam int N     = IMG_W * IMG_H;
    localparam int BCOLS = IMG_W / 8;
    localparam int BC_W  = (BCOLS > 1) ? $clog2(BCOLS) : 1;
    localparam int CNT_W = $clog2(N + DCT_LATENCY + 3) + 1;

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(N);
    localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(DCT_LATENCY + 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DCT_LATENCY + N);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DCT_LATENCY + N + 1);
    localparam logic [BC_W-1:0]  BC_LAST    = BC_W'(BCOLS - 1);

    localparam logic [ADDR_W-1:0] STEP_ROW  = ADDR_W'(IMG_W - 7);
    localparam logic [ADDR_W-1:0] STEP_BLK  = ADDR_W'(7 * IMG_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cyc_q;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [BC_W-1:0]   bc_q;
    logic              done_q;
    logic [11:0]       coef_data_q;
    logic              coef_valid_q;
    logic [BLK_W-1:0]  coef_blk_q;
    logic [5:0]        coef_idx_q;

    logic       busy;
    logic       feeding;
    logic       capture;
    logic       enb;
    logic       feed_px;
    logic       c_last;
    logic       r_last;
    logic       bc_last;

    // During FEED cyc_q equals the read index k, so its low bits are c and r.
    assign c_last  = cyc_q[2:0] == 3'd7;
    assign r_last  = cyc_q[5:3] == 3'd7;
    assign bc_last = bc_q == BC_LAST;

    assign busy    = state_q != IDLE;
    assign feeding = state_q == FEED && state_d == FEED;
    assign capture = busy && cyc_q >= CAP_FIRST && cyc_q <= CAP_LAST;
    assign enb     = busy && cyc_q >= 1 && cyc_q <= CAP_LAST;
    assign feed_px = busy && cyc_q >= 1 && cyc_q <= PIX_LAST;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FEED;
            FEED:    if (cyc_q == FEED_LAST) state_d = DRAIN;
            DRAIN:   if (cyc_q == DRAIN_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Incremental raster address: no multiply in the step path.
    always_comb begin
        addr_nxt = addr_q + 1'b1;
        unique case (1'b1)
            !c_last:                     addr_nxt = addr_q + 1'b1;
            c_last && !r_last:           addr_nxt = addr_q + STEP_ROW;
            c_last && r_last && !bc_last: addr_nxt = addr_q - STEP_BLK;
            c_last && r_last && bc_last:  addr_nxt = addr_q + 1'b1;
            default:                     addr_nxt = addr_q + 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            addr_q       <= '0;
            bc_q         <= '0;
            done_q       <= 1'b0;
            coef_data_q  <= '0;
            coef_valid_q <= 1'b0;
            coef_blk_q   <= '0;
            coef_idx_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= state_q == DRAIN && state_d == IDLE;

            if (state_q == IDLE) cyc_q <= '0;
            else                 cyc_q <= cyc_q + 1'b1;

            if (feeding) begin
                addr_q <= addr_nxt;
                if (c_last && r_last)
                    bc_q <= bc_last ? '0 : bc_q + 1'b1;
            end else begin
                addr_q <= '0;
                bc_q   <= '0;
            end

            if (capture) begin
                coef_data_q  <= bus.dct_data_out;
                coef_valid_q <= 1'b1;
                if (!coef_valid_q) begin
                    coef_idx_q <= '0;
                    coef_blk_q <= '0;
                end else begin
                    coef_idx_q <= coef_idx_q + 1'b1;
                    if (coef_idx_q == 6'd63)
                        coef_blk_q <= coef_blk_q + 1'b1;
                end
            end else begin
                coef_data_q  <= '0;
                coef_valid_q <= 1'b0;
                coef_idx_q   <= '0;
                coef_blk_q   <= '0;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.mem_rd_en   = state_q == FEED;
    assign bus.mem_addr    = addr_q;
    assign bus.dct_enb     = enb;
    assign bus.dct_data_in = feed_px ? bus.mem_rd_data : 8'd0;
    assign bus.coef_data   = coef_data_q;
    assign bus.coef_valid  = coef_valid_q;
    assign bus.coef_blk    = coef_blk_q;
    assign bus.coef_idx    = coef_idx_q;
endmodule

// File: tb/tb_dct_frame_sequencer.sv
// Bench for dct_frame_sequencer: 16x8 image, dct_top modelled
// as a 5-stage sign-extending delay line.
module tb_dct_frame_sequencer;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int L  = 5;
    localparam int N  = W * H;
    localparam int AW = 7;
    localparam int BW = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dct_frame_sequencer_if #(.ADDR_W(AW), .BLK_W(BW)) bus ();

    dct_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .DCT_LATENCY(L),
        .ADDR_W(AW), .BLK_W(BW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0]  ram [N];
    logic [7:0]  rd_q;
    logic [11:0] dl [L];

    always_ff @(posedge clk) begin
        if (bus.mem_rd_en) rd_q <= ram[bus.mem_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) dl[i] <= '0;
        end else begin
            dl[0] <= {{4{bus.dct_data_in[7]}}, bus.dct_data_in};
            for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
        end
    end

    assign bus.mem_rd_data  = rd_q;
    assign bus.dct_data_out = dl[L-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic int addr_of(input int k);
        int b, br, bc;
        b  = k / 64;
        br = b / (W / 8);
        bc = b % (W / 8);
        return (br * 8 + (k / 8) % 8) * W + bc * 8 + k % 8;
    endfunction

    function automatic int coef_of(input int k);
        int p;
        p = int'(ram[addr_of(k)]);
        if (p >= 128) p = p - 256;
        return p & 32'hfff;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".busy"},  32'(bus.busy), 0);
        chk({tag, ".done"},  32'(bus.done), 0);
        chk({tag, ".rd_en"}, 32'(bus.mem_rd_en), 0);
        chk({tag, ".addr"},  32'(bus.mem_addr), 0);
        chk({tag, ".din"},   32'(bus.dct_data_in), 0);
        chk({tag, ".enb"},   32'(bus.dct_enb), 0);
        chk({tag, ".cdata"}, 32'(bus.coef_data), 0);
        chk({tag, ".valid"}, 32'(bus.coef_valid), 0);
        chk({tag, ".blk"},   32'(bus.coef_blk), 0);
        chk({tag, ".idx"},   32'(bus.coef_idx), 0);
    endtask

    // j counts cycles after the start edge; cycle j=N+L+3 is done.
    task automatic run_frame(input bit hold, input bit poke);
        int k;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        for (int j = 1; j <= N + L + 3; j++) begin
            @(negedge clk);
            chk("busy", 32'(bus.busy), 32'(j <= N + L + 2));
            chk("rd_en", 32'(bus.mem_rd_en), 32'(j <= N));
            if (j <= N)
                chk("addr", 32'(bus.mem_addr), addr_of(j - 1));
            chk("enb", 32'(bus.dct_enb),
                32'(j >= 2 && j <= N + L + 1));
            if (j >= 2 && j <= N + L + 1)
                chk("din", 32'(bus.dct_data_in),
                    (j <= N + 1) ? int'(ram[addr_of(j - 2)]) : 0);
            chk("valid", 32'(bus.coef_valid),
                32'(j >= L + 3 && j <= L + N + 2));
            if (j >= L + 3 && j <= L + N + 2) begin
                k = j - L - 3;
                chk("cdata", 32'(bus.coef_data), coef_of(k));
                chk("blk", 32'(bus.coef_blk), k / 64);
                chk("idx", 32'(bus.coef_idx), k % 64);
            end
            chk("done", 32'(bus.done), 32'(j == N + L + 3));
            if (poke)
                bus.start = (j <= N + L + 1) ?
                    1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        for (int a = 0; a < N; a++) ram[a] = 8'(a & 255);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        run_frame(1'b0, 1'b0);
        @(negedge clk);
        check_idle("after1");

        for (int a = 0; a < N; a++) ram[a] = 8'($urandom);
        run_frame(1'b1, 1'b0);
        run_frame(1'b0, 1'b0);
        @(negedge clk);
        check_idle("b2b");

        for (int a = 0; a < N; a++) ram[a] = 8'($urandom);
        run_frame(1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check_idle("poke");
        end

        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (70) @(negedge clk);
        chk("rd_en70", 32'(bus.mem_rd_en), 1);
        chk("addr70", 32'(bus.mem_addr), addr_of(69));
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst70");
        rst = 1'b0;
        repeat (N + L + 4) begin
            @(negedge clk);
            chk("nodone", 32'(bus.done), 0);
            chk("nobusy", 32'(bus.busy), 0);
        end

        for (int a = 0; a < N; a++) ram[a] = 8'(a & 255);
        run_frame(1'b0, 1'b0);
        @(negedge clk);
        check_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
